rls_deserializer: RTL and testbench

Serial-in, parallel-out receiver. It is the receiving end of the serial stream produced by the RLS803-style shift register path. It assembles WIDTH serial bits into a parallel word, in either bit order, and presents each word on a valid/ready output. The sender shifts left (MSB first) or right (LSB first). This block rebuilds the word with the matching shift direction.

---
 rtl/rls_deserializer.sv | 117 +++++++++++
 tb/tb_rls_deserializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rls_deserializer.sv
// Serial-in, parallel-out receiver: assembles WIDTH bits (MSB or LSB first)
// into a word and presents it on a valid/ready output with a sticky overrun flag.
module rls_deserializer #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             direction,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             overrun,
  input  logic             clear_overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_dir, w_dir_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_overrun, w_overrun_nxt;

  logic             w_complete;
  logic             w_start;
  logic             w_sel_dir;
  logic             w_accept;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_count_nxt   = r_count;
    w_overrun_nxt = r_overrun;

    // A frame_start on the completing bit is not a restart; that bit finishes the frame.
    w_complete = bit_valid && (r_state == SHIFT) && (r_count == CW'(WIDTH - 1));
    w_start    = bit_valid && frame_start && !w_complete;
    w_sel_dir  = w_start ? direction : r_dir;
    w_base     = w_start ? '0 : r_shift;
    w_shifted  = w_sel_dir ? {w_base[WIDTH-2:0], serial_in}
                           : {serial_in, w_base[WIDTH-1:1]};
    w_accept   = !r_valid || data_ready;

    if (w_start) begin
      w_state_nxt = SHIFT;
      w_dir_nxt   = direction;
      w_shift_nxt = w_shifted;
      w_count_nxt = CW'(1);
    end else if (bit_valid && (r_state == SHIFT)) begin
      w_shift_nxt = w_shifted;
      if (w_complete) begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end

    if (r_valid && data_ready) w_valid_nxt = 1'b0;
    if (clear_overrun) w_overrun_nxt = 1'b0;

    // Completion is evaluated last so a same-edge consume or clear_overrun loses to it.
    if (w_complete) begin
      if (w_accept) begin
        w_data_nxt  = w_shifted;
        w_valid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and a synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= IDLE;
      r_dir     <= 1'b0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_count   <= w_count_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign busy       = (r_state == SHIFT);
  assign bit_count  = r_count;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_rls_deserializer.sv
// Directed self-checking bench for rls_deserializer (WIDTH=8).
module tb_rls_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             clear;
  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic             direction;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             overrun;
  logic             clear_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  rls_deserializer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .clear        (clear),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .direction    (direction),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .busy         (busy),
    .bit_count    (bit_count),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic fs);
    serial_in   = b;
    bit_valid   = 1'b1;
    frame_start = fs;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] word, input logic msb_first);
    direction = msb_first;
    for (int i = 0; i < 8; i++)
      drive_bit(msb_first ? word[7-i] : word[i], i == 0);
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    clear         = 1'b1;
    serial_in     = 1'b0;
    bit_valid     = 1'b0;
    frame_start   = 1'b0;
    direction     = 1'b0;
    data_ready    = 1'b0;
    clear_overrun = 1'b0;
    tick();
    tick();
    clear = 1'b0;

    chk("reset data_out",   32'(data_out),   32'h0);
    chk("reset data_valid", 32'(data_valid), 32'h0);
    chk("reset busy",       32'(busy),       32'h0);
    chk("reset bit_count",  32'(bit_count),  32'h0);
    chk("reset overrun",    32'(overrun),    32'h0);

    // MSB-first 0xB2, bit_valid continuous
    direction = 1'b1;
    drive_bit(1'b1, 1'b1);
    chk("msb first bit busy",  32'(busy),      32'h1);
    chk("msb first bit count", 32'(bit_count), 32'h1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    chk("msb 7 bits count", 32'(bit_count),  32'h7);
    chk("msb 7 bits valid", 32'(data_valid), 32'h0);
    drive_bit(1'b0, 1'b0);
    chk("msb data_out",  32'(data_out),   32'hB2);
    chk("msb valid",     32'(data_valid), 32'h1);
    chk("msb busy",      32'(busy),       32'h0);
    chk("msb bit_count", 32'(bit_count),  32'h0);
    tick();
    chk("msb held valid", 32'(data_valid), 32'h1);
    chk("msb held data",  32'(data_out),   32'hB2);
    consume();
    chk("msb consumed", 32'(data_valid), 32'h0);

    // LSB-first 0xB2 with a 3-cycle gap after bit 4; direction flip during gap is ignored
    direction = 1'b0;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    direction = 1'b1;
    tick();
    tick();
    tick();
    chk("gap bit_count", 32'(bit_count), 32'h4);
    chk("gap busy",      32'(busy),      32'h1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("lsb busy before last", 32'(busy), 32'h1);
    drive_bit(1'b1, 1'b0);
    chk("lsb data_out", 32'(data_out),   32'hB2);
    chk("lsb valid",    32'(data_valid), 32'h1);
    chk("lsb busy",     32'(busy),       32'h0);
    consume();

    // Overrun then recovery
    send_frame(8'h55, 1'b1);
    chk("ovr first data", 32'(data_out), 32'h55);
    chk("ovr first flag", 32'(overrun),  32'h0);
    send_frame(8'hAA, 1'b1);
    chk("ovr kept data", 32'(data_out),   32'h55);
    chk("ovr flag",      32'(overrun),    32'h1);
    chk("ovr valid",     32'(data_valid), 32'h1);
    consume();
    chk("ovr consumed",     32'(data_valid), 32'h0);
    chk("ovr sticky",       32'(overrun),    32'h1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr cleared", 32'(overrun), 32'h0);

    // Same-edge consume and completion
    send_frame(8'h0F, 1'b1);
    chk("same edge first", 32'(data_out), 32'h0F);
    w = 8'hF0;
    direction = 1'b1;
    for (int i = 0; i < 7; i++) drive_bit(w[7-i], i == 0);
    chk("same edge old held", 32'(data_out), 32'h0F);
    data_ready = 1'b1;
    drive_bit(w[0], 1'b0);
    data_ready = 1'b0;
    chk("same edge data",    32'(data_out),   32'hF0);
    chk("same edge valid",   32'(data_valid), 32'h1);
    chk("same edge overrun", 32'(overrun),    32'h0);
    consume();

    // Restart mid-frame
    direction = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    chk("restart pre count", 32'(bit_count), 32'h3);
    drive_bit(1'b1, 1'b1);
    chk("restart count", 32'(bit_count), 32'h1);
    w = 8'h81;
    for (int i = 1; i < 8; i++) drive_bit(w[7-i], 1'b0);
    chk("restart data",    32'(data_out), 32'h81);
    chk("restart overrun", 32'(overrun),  32'h0);
    consume();

    // Mid-frame clear
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    chk("pre clear count", 32'(bit_count), 32'h5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear data_out",  32'(data_out),   32'h0);
    chk("clear valid",     32'(data_valid), 32'h0);
    chk("clear busy",      32'(busy),       32'h0);
    chk("clear bit_count", 32'(bit_count),  32'h0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("no start busy",  32'(busy),      32'h0);
    chk("no start count", 32'(bit_count), 32'h0);
    send_frame(8'h3C, 1'b0);
    chk("after clear data", 32'(data_out), 32'h3C);
    consume();

    // Direction toggled mid-frame; frame_start on the completing bit is ignored
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      direction = (i < 3);
      drive_bit(w[7-i], (i == 0) || (i == 7));
    end
    chk("dir toggle data",  32'(data_out),  32'hC3);
    chk("last fs busy",     32'(busy),      32'h0);
    chk("last fs count",    32'(bit_count), 32'h0);
    consume();

    // Back-to-back: new frame starts on the cycle right after completion
    send_frame(8'h5A, 1'b1);
    send_frame(8'h96, 1'b0);
    chk("b2b held data", 32'(data_out), 32'h5A);
    chk("b2b overrun",   32'(overrun),  32'h1);
    consume();
    send_frame(8'h96, 1'b0);
    chk("b2b second data", 32'(data_out), 32'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
